// File: rtl/rx_chnl_ctrl_pkg.sv
// rtl/rx_chnl_ctrl_pkg.sv - shared FSM state type and beat-sizing helpers for the RX channel consumer
package rx_chnl_ctrl_pkg;

    // Controller states: request capture, one-cycle acknowledge, beat transfer,
    // output drain, completion pulse, then wait for the request to drop.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACK     = 3'd1,
        S_DATA    = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4,
        S_WAITLOW = 3'd5
    } state_t;

    // Number of 32-bit words carried by one channel beat.
    function automatic int unsigned words_per_beat(input int unsigned data_width);
        return data_width / 32;
    endfunction

    // Beats needed to carry len words; a partial final beat counts as a full beat.
    function automatic logic [31:0] ceil_beats(input logic [31:0] len, input int unsigned wpb);
        logic [31:0] w_div;
        logic [31:0] w_q;
        w_div = wpb;
        w_q   = len / w_div;
        if ((len % w_div) != 32'd0) begin
            w_q = w_q + 32'd1;
        end
        return w_q;
    endfunction

endpackage

// File: rtl/rx_chnl_out_reg.sv
// rtl/rx_chnl_out_reg.sv - single-entry downstream holding register with valid and last tracking
module rx_chnl_out_reg #(
    parameter int unsigned C_DATA_WIDTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [C_DATA_WIDTH-1:0] i_data,
    input  logic                    i_last,
    input  logic                    i_set_last,
    input  logic                    i_ready,
    output logic [C_DATA_WIDTH-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_last
);

    logic [C_DATA_WIDTH-1:0] r_data;
    logic                    r_valid;
    logic                    r_last;

    // Load a new beat (allowed in the same cycle the old one is accepted),
    // otherwise retire on accept, otherwise make a late end-of-stream mark sticky.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (r_valid && i_set_last) begin
            r_last  <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    // The early-end mark also shows combinationally so a beat accepted in the
    // very cycle the transfer is cut short still leaves flagged as last.
    assign o_last  = r_last | (r_valid & i_set_last);

endmodule

// File: rtl/rx_chnl_consumer_ctrl.sv
// rtl/rx_chnl_consumer_ctrl.sv - RX channel consumer FSM (idle timeout optional via RX_CHNL_CONSUMER_TIMEOUT_EN)
module rx_chnl_consumer_ctrl
    import rx_chnl_ctrl_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned C_TIMEOUT    = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_chnl_rx,
    output logic                    o_chnl_rx_ack,
    input  logic                    i_chnl_rx_last,
    input  logic [31:0]             i_chnl_rx_len,
    input  logic [30:0]             i_chnl_rx_off,
    input  logic [C_DATA_WIDTH-1:0] i_chnl_rx_data,
    input  logic                    i_chnl_rx_data_valid,
    output logic                    o_chnl_rx_data_ren,
    output logic [C_DATA_WIDTH-1:0] o_out_data,
    output logic                    o_out_valid,
    output logic                    o_out_last,
    input  logic                    i_out_ready,
    output logic [31:0]             o_xfer_len,
    output logic [30:0]             o_xfer_off,
    output logic                    o_xfer_last,
    output logic [31:0]             o_xfer_words,
    output logic                    o_xfer_done,
    output logic                    o_xfer_short,
    output logic                    o_xfer_timeout
);

    localparam int unsigned WPB = words_per_beat(C_DATA_WIDTH);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_xfer_len;
    logic [30:0] r_xfer_off;
    logic        r_xfer_last;
    logic [31:0] r_xfer_words;
    logic        r_short;
    logic [31:0] r_remaining;

    logic        w_out_valid;
    logic        w_capture;
    logic        w_ren;
    logic        w_last_beat;
    logic        w_short_hit;
    logic        w_to_hit;
    logic        w_early_end;
    logic [32:0] w_words_sum;
    logic [31:0] w_words_next;

    assign w_capture   = (r_state == S_IDLE) && i_chnl_rx;
    // A beat is taken only when the holding register is free or emptying this cycle.
    assign w_ren       = (r_state == S_DATA) && i_chnl_rx_data_valid &&
                         (!w_out_valid || i_out_ready) && (r_remaining != 32'd0);
    assign w_last_beat = (r_remaining == 32'd1);
    // Sender gave up: request dropped with nothing on the bus and beats still owed.
    assign w_short_hit = (r_state == S_DATA) && !i_chnl_rx && !i_chnl_rx_data_valid &&
                         (r_remaining != 32'd0);
    assign w_early_end = w_short_hit | w_to_hit;

    // Word count advances a full beat but never past the requested length.
    assign w_words_sum  = {1'b0, r_xfer_words} + 33'(WPB);
    assign w_words_next = (w_words_sum > {1'b0, r_xfer_len}) ? r_xfer_len : w_words_sum[31:0];

`ifdef RX_CHNL_CONSUMER_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_timeout;

    assign w_to_hit = (r_state == S_DATA) && !i_chnl_rx_data_valid &&
                      (r_remaining != 32'd0) && (r_to_cnt == 32'(C_TIMEOUT - 1));

    // Count consecutive starved DATA cycles; any presented beat restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= 32'd0;
        end else if (w_capture || i_chnl_rx_data_valid) begin
            r_to_cnt <= 32'd0;
        end else if (r_state == S_DATA) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    // Timeout flag is cleared by a new request and set when the idle limit is hit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_capture) begin
            r_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_timeout <= 1'b1;
        end
    end

    assign o_xfer_timeout = r_timeout;
`else
    assign w_to_hit       = 1'b0;
    assign o_xfer_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_chnl_rx) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                w_next = (r_xfer_len == 32'd0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
                if (r_remaining == 32'd0) begin
                    w_next = S_DRAIN;
                end else if (w_ren && w_last_beat) begin
                    w_next = S_DRAIN;
                end else if (w_early_end) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_out_valid || i_out_ready) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_WAITLOW;
            end
            S_WAITLOW: begin
                if (!i_chnl_rx) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Transfer attributes and progress: captured on request, held until the next one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xfer_len   <= 32'd0;
            r_xfer_off   <= 31'd0;
            r_xfer_last  <= 1'b0;
            r_xfer_words <= 32'd0;
            r_short      <= 1'b0;
            r_remaining  <= 32'd0;
        end else if (w_capture) begin
            r_xfer_len   <= i_chnl_rx_len;
            r_xfer_off   <= i_chnl_rx_off;
            r_xfer_last  <= i_chnl_rx_last;
            r_xfer_words <= 32'd0;
            r_short      <= 1'b0;
            r_remaining  <= ceil_beats(i_chnl_rx_len, WPB);
        end else begin
            if (w_ren) begin
                r_remaining  <= r_remaining - 32'd1;
                r_xfer_words <= w_words_next;
            end
            if (w_early_end) begin
                r_short <= 1'b1;
            end
        end
    end

    rx_chnl_out_reg #(
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_out_reg (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_ren),
        .i_data     (i_chnl_rx_data),
        .i_last     (w_last_beat),
        .i_set_last (w_early_end),
        .i_ready    (i_out_ready),
        .o_data     (o_out_data),
        .o_valid    (w_out_valid),
        .o_last     (o_out_last)
    );

    assign o_out_valid        = w_out_valid;
    assign o_chnl_rx_ack      = (r_state == S_ACK);
    assign o_chnl_rx_data_ren = w_ren;
    assign o_xfer_done        = (r_state == S_DONE);
    assign o_xfer_len         = r_xfer_len;
    assign o_xfer_off         = r_xfer_off;
    assign o_xfer_last        = r_xfer_last;
    assign o_xfer_words       = r_xfer_words;
    assign o_xfer_short       = r_short;

endmodule

// File: tb/tb_rx_chnl_consumer_ctrl.sv
// tb/tb_rx_chnl_consumer_ctrl.sv - scoreboard bench for rx_chnl_consumer_ctrl
module tb_rx_chnl_consumer_ctrl;

    localparam int W  = 64;
    localparam int TO = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_chnl_rx = 1'b0;
    logic          o_chnl_rx_ack;
    logic          i_chnl_rx_last = 1'b0;
    logic [31:0]   i_chnl_rx_len = '0;
    logic [30:0]   i_chnl_rx_off = '0;
    logic [W-1:0]  i_chnl_rx_data = '0;
    logic          i_chnl_rx_data_valid = 1'b0;
    logic          o_chnl_rx_data_ren;
    logic [W-1:0]  o_out_data;
    logic          o_out_valid;
    logic          o_out_last;
    logic          i_out_ready = 1'b1;
    logic [31:0]   o_xfer_len;
    logic [30:0]   o_xfer_off;
    logic          o_xfer_last;
    logic [31:0]   o_xfer_words;
    logic          o_xfer_done;
    logic          o_xfer_short;
    logic          o_xfer_timeout;

    rx_chnl_consumer_ctrl #(
        .C_DATA_WIDTH (W),
        .C_TIMEOUT    (TO)
    ) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_chnl_rx            (i_chnl_rx),
        .o_chnl_rx_ack        (o_chnl_rx_ack),
        .i_chnl_rx_last       (i_chnl_rx_last),
        .i_chnl_rx_len        (i_chnl_rx_len),
        .i_chnl_rx_off        (i_chnl_rx_off),
        .i_chnl_rx_data       (i_chnl_rx_data),
        .i_chnl_rx_data_valid (i_chnl_rx_data_valid),
        .o_chnl_rx_data_ren   (o_chnl_rx_data_ren),
        .o_out_data           (o_out_data),
        .o_out_valid          (o_out_valid),
        .o_out_last           (o_out_last),
        .i_out_ready          (i_out_ready),
        .o_xfer_len           (o_xfer_len),
        .o_xfer_off           (o_xfer_off),
        .o_xfer_last          (o_xfer_last),
        .o_xfer_words         (o_xfer_words),
        .o_xfer_done          (o_xfer_done),
        .o_xfer_short         (o_xfer_short),
        .o_xfer_timeout       (o_xfer_timeout)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic [31:0] len;
        logic [30:0] off;
        logic        last;
        logic [31:0] words;
        logic        short_f;
        logic        to_f;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_ack    = 0;
    int n_ren    = 0;
    int n_done   = 0;
    int cyc      = 0;
    int done_cyc = 0;
    bit chk_beats    = 1'b1;
    bit ready_toggle = 1'b0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    // Downstream ready: steady high, or alternating when backpressure is exercised.
    always @(posedge i_clk) begin
        #1;
        i_out_ready = ready_toggle ? ~i_out_ready : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mk_data(input logic [31:0] len, input int idx);
        return {len ^ 32'hC0DE0000, 32'(idx) ^ 32'h5A5A0000};
    endfunction

    // Monitor: pops the scoreboards whenever the DUT presents a beat or a completion.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_chnl_rx_ack) n_ack++;
            if (o_chnl_rx_data_ren) n_ren++;
            if (o_out_valid && !i_out_ready)
                check("ren_under_backpressure", 64'(o_chnl_rx_data_ren), 64'd0);
            if (o_out_valid && i_out_ready && chk_beats) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", o_out_data);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_data", 64'(o_out_data), 64'(b.data));
                    check("beat_last", 64'(o_out_last), 64'(b.last));
                end
            end
            if (o_xfer_done) begin
                n_done++;
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got pulse expected none");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_words",   64'(o_xfer_words),   64'(d.words));
                    check("done_short",   64'(o_xfer_short),   64'(d.short_f));
                    check("done_timeout", 64'(o_xfer_timeout), 64'(d.to_f));
                    check("done_len",     64'(o_xfer_len),     64'(d.len));
                    check("done_off",     64'(o_xfer_off),     64'(d.off));
                    check("done_last",    64'(o_xfer_last),    64'(d.last));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},     64'(o_chnl_rx_ack),      64'd0);
        check({tag, "_ren"},     64'(o_chnl_rx_data_ren), 64'd0);
        check({tag, "_odata"},   64'(o_out_data),         64'd0);
        check({tag, "_ovalid"},  64'(o_out_valid),        64'd0);
        check({tag, "_olast"},   64'(o_out_last),         64'd0);
        check({tag, "_len"},     64'(o_xfer_len),         64'd0);
        check({tag, "_off"},     64'(o_xfer_off),         64'd0);
        check({tag, "_xlast"},   64'(o_xfer_last),        64'd0);
        check({tag, "_words"},   64'(o_xfer_words),       64'd0);
        check({tag, "_done"},    64'(o_xfer_done),        64'd0);
        check({tag, "_short"},   64'(o_xfer_short),       64'd0);
        check({tag, "_timeout"}, 64'(o_xfer_timeout),     64'd0);
    endtask

    // One transfer: expectations are pushed first, then the source is driven.
    task automatic xfer(input logic [31:0] len, input logic [30:0] off, input logic lst,
                        input int n_supply, input bit drop, input int exp_beats,
                        input logic [31:0] exp_words, input bit exp_short, input bit exp_to,
                        input bit exp_last_on_final);
        int ack0, ren0, done0, req_cyc, idx;
        done_t d;
        for (int i = 0; i < exp_beats; i++)
            beat_q.push_back('{mk_data(len, i), exp_last_on_final && (i == exp_beats - 1)});
        d.len = len; d.off = off; d.last = lst;
        d.words = exp_words; d.short_f = exp_short; d.to_f = exp_to;
        done_q.push_back(d);
        ack0 = n_ack; ren0 = n_ren; done0 = n_done;
        @(posedge i_clk); #1;
        req_cyc = cyc;
        i_chnl_rx = 1'b1; i_chnl_rx_len = len; i_chnl_rx_off = off; i_chnl_rx_last = lst;
        idx = 0;
        for (int c = 0; c < 400 && n_done == done0; c++) begin
            if (idx < n_supply) begin
                i_chnl_rx_data_valid = 1'b1;
                i_chnl_rx_data = mk_data(len, idx);
            end else begin
                i_chnl_rx_data_valid = 1'b0;
                if (drop) i_chnl_rx = 1'b0;
            end
            @(negedge i_clk);
            if (o_chnl_rx_data_ren) idx++;
            @(posedge i_clk); #1;
        end
        check("done_seen", 64'(n_done - done0), 64'd1);
        i_chnl_rx = 1'b0;
        i_chnl_rx_data_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("ack_cycles", 64'(n_ack - ack0), 64'd1);
        check("ren_count", 64'(n_ren - ren0), 64'(exp_beats));
        if (len == 32'd0) check("len0_done_latency", 64'(done_cyc - req_cyc), 64'd2);
        check("hold_words", 64'(o_xfer_words), 64'(exp_words));
        check("hold_len",   64'(o_xfer_len),   64'(len));
    endtask

    initial begin
        int ren0, done0;
        repeat (2) @(negedge i_clk);
        check_all_zero("reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);

        // LEN=8 -> 4 beats, words 8
        xfer(32'd8, 31'h12, 1'b1, 4, 1'b0, 4, 32'd8, 1'b0, 1'b0, 1'b1);
        // LEN=5 -> 3 beats, words clipped to 5
        xfer(32'd5, 31'h7FFF_0001, 1'b0, 3, 1'b0, 3, 32'd5, 1'b0, 1'b0, 1'b1);
        // LEN=0 -> ack then done, no beats
        xfer(32'd0, 31'd3, 1'b1, 0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
        // LEN=8 with ready alternating
        ready_toggle = 1'b1;
        xfer(32'd8, 31'd0, 1'b0, 4, 1'b0, 4, 32'd8, 1'b0, 1'b0, 1'b1);
        ready_toggle = 1'b0;
        repeat (2) @(posedge i_clk);
        // LEN=16, request dropped after 2 beats -> short, words 4
        xfer(32'd16, 31'd9, 1'b1, 2, 1'b1, 2, 32'd4, 1'b1, 1'b0, 1'b1);
`ifdef RX_CHNL_CONSUMER_TIMEOUT_EN
        // LEN=16, one beat then starved -> timeout and short
        xfer(32'd16, 31'd5, 1'b0, 1, 1'b0, 1, 32'd2, 1'b1, 1'b1, 1'b0);
`endif

        // Reset mid-DATA: everything clears, no completion pulse
        chk_beats = 1'b0;
        ren0 = n_ren; done0 = n_done;
        @(posedge i_clk); #1;
        i_chnl_rx = 1'b1; i_chnl_rx_len = 32'd16; i_chnl_rx_off = 31'd1;
        i_chnl_rx_data_valid = 1'b1; i_chnl_rx_data = 64'hDEAD_BEEF_0000_0001;
        for (int c = 0; c < 50 && (n_ren - ren0) < 2; c++) @(posedge i_clk);
        #1;
        check("rst_reached_data", 64'((n_ren - ren0) >= 2), 64'd1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_all_zero("midrst");
        @(posedge i_clk); #1;
        i_chnl_rx = 1'b0; i_chnl_rx_data_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("post_rst_ack",   64'(o_chnl_rx_ack),   64'd0);
        check("post_rst_valid", 64'(o_out_valid),     64'd0);
        check("post_rst_done",  64'(n_done - done0),  64'd0);
        chk_beats = 1'b1;

        // Normal transfer after reset
        xfer(32'd8, 31'd2, 1'b1, 4, 1'b0, 4, 32'd8, 1'b0, 1'b0, 1'b1);

        check("beat_q_empty", 64'(beat_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rx_chnl_consumer_ctrl.md
RX_CHNL_CONSUMER_CTRL -- requirements
Module: rx_chnl_consumer_ctrl

Interface
REQ-001 Parameter: C_DATA_WIDTH, default 64, channel data width in bits; legal values 32, 64, 128. WPB = C_DATA_WIDTH/32 words per beat.
REQ-002 Parameter: C_TIMEOUT, default 1024, idle-cycle limit used only when the timeout is compiled in.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low. Ports are listed below.
REQ-004 CLK  in  1  sole clock; all logic on its rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 CHNL_RX  in  1  transfer request, held high for the whole transfer.
REQ-007 CHNL_RX_ACK  out  1  request acknowledge.
REQ-008 CHNL_RX_LAST / CHNL_RX_LEN / CHNL_RX_OFF  in  1/32/31  transfer attributes; LEN is in 32-bit words.
REQ-009 CHNL_RX_DATA / CHNL_RX_DATA_VALID  in  W/1  inbound beat and its valid.
REQ-010 CHNL_RX_DATA_REN  out  1  beat consumed this cycle.
REQ-011 OUT_DATA / OUT_VALID / OUT_LAST  out  W/1/1  downstream beat, its valid, and final-beat flag.
REQ-012 OUT_READY  in  1  downstream accept.
REQ-013 XFER_LEN / XFER_OFF / XFER_LAST  out  32/31/1  attributes captured at request.
REQ-014 XFER_WORDS  out  32  words delivered so far.
REQ-015 XFER_DONE / XFER_SHORT / XFER_TIMEOUT  out  1/1/1  completion pulse, short flag, and timeout flag.

Function
REQ-016 The FSM SHALL have the states IDLE, ACK, DATA, DRAIN, DONE and WAITLOW.
REQ-017 IDLE: on CHNL_RX=1, the block SHALL capture LEN, OFF and LAST; clear XFER_WORDS, SHORT and TIMEOUT; load beats-remaining with ceil(LEN/WPB); and go to ACK.
REQ-018 ACK: CHNL_RX_ACK SHALL be high for exactly this one cycle; next state is DATA, or DONE if LEN=0.
REQ-019 DATA: CHNL_RX_DATA_REN SHALL equal CHNL_RX_DATA_VALID AND (NOT OUT_VALID OR OUT_READY) AND remaining>0; it is combinational.
REQ-020 An accepted beat SHALL appear on OUT_DATA with OUT_VALID set the next cycle (1-cycle latency). OUT_VALID SHALL hold until OUT_READY=1.
REQ-021 An accepted beat SHALL decrement remaining and add WPB to XFER_WORDS, clipped to XFER_LEN.
REQ-022 OUT_LAST SHALL accompany the beat that takes remaining to 0.
REQ-023 When remaining reaches 0, the FSM SHALL go to DRAIN.
REQ-024 If CHNL_RX=0 and CHNL_RX_DATA_VALID=0 in DATA with remaining>0, XFER_SHORT SHALL be set, the current OUT beat (if any) SHALL be marked OUT_LAST, and the FSM SHALL go to DRAIN.
REQ-025 DRAIN: the FSM SHALL wait until OUT_VALID=0 or (OUT_VALID AND OUT_READY), then go to DONE.
REQ-026 DONE: XFER_DONE SHALL be a single-cycle pulse; the FSM then goes to WAITLOW.
REQ-027 WAITLOW: the FSM SHALL return to IDLE when CHNL_RX=0; no REN is issued in this state.
REQ-028 Simultaneous OUT_READY and a new accept SHALL sustain one beat per cycle with no bubble.
REQ-029 XFER_* outputs SHALL hold their values until the next request is captured.

Reset
REQ-030 While RST_N=0, the FSM SHALL be in IDLE and every output SHALL be 0 (OUT_DATA included), except that REN is combinationally 0 in IDLE.
REQ-031 Reset assertion mid-transfer SHALL abort the transfer immediately with no XFER_DONE; after release the FSM restarts in IDLE and waits for CHNL_RX.

Configuration
REQ-032 With RX_CHNL_CONSUMER_TIMEOUT_EN defined, a counter SHALL count consecutive DATA cycles with CHNL_RX_DATA_VALID=0. The counter clears on any accepted beat.
REQ-033 When that counter reaches C_TIMEOUT, XFER_TIMEOUT and XFER_SHORT SHALL be set and the FSM SHALL go to DRAIN.
REQ-034 Without the macro, no counter SHALL exist and XFER_TIMEOUT SHALL be tied to 0.

Structure
REQ-035 Package rx_chnl_ctrl_pkg SHALL hold the FSM state enum, the WPB constant function and the ceil-beats function.
REQ-036 The output holding register plus its valid/last logic SHALL be a sub-module named rx_chnl_out_reg.

Verification
REQ-037 W=64, LEN=8, VALID continuous, READY=1 -> ACK 1 cycle; 4 REN; OUT_LAST on beat 4; XFER_WORDS=8; XFER_DONE pulse; SHORT=0.
REQ-038 W=64, LEN=5 -> 3 beats; XFER_WORDS=5; OUT_LAST on beat 3.
REQ-039 LEN=0 -> ACK, then XFER_DONE 2 cycles after request; no REN.
REQ-040 LEN=8, READY toggling 1/0 -> no beat lost or duplicated; REN never high while OUT_VALID=1 and READY=0.
REQ-041 LEN=16, CHNL_RX drops after 2 beats -> XFER_SHORT=1, XFER_WORDS=4, XFER_DONE.
REQ-042 With the macro, C_TIMEOUT=16, VALID held 0 after 1 beat -> XFER_TIMEOUT=1 after 16 cycles; RST_N pulse mid-DATA -> all outputs 0 and IDLE.
